// File: rtl/arbiter_response_engine.sv
// Arbiter-PUF far-end controller: drives the launch pulse and challenge
// slices into the delay line, synchronises the two racing outputs, decides
// each trial, majority-votes REPEAT trials per bit and assembles the
// N_RESP-bit response word.
//
// Handshake: a request is accepted only when istart is high while the
// engine is idle (obusy=0). There is no back-pressure; the result is
// presented by a single-cycle odone strobe, and oresponse/oerror/otie_cnt
// stay stable afterwards until the next accepted request.
module arbiter_response_engine #(
  parameter int N_STAGE       = 3,
  parameter int N_RESP        = 8,
  parameter int REPEAT        = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        iclk,
  input  logic                        irst,
  input  logic                        istart,
  input  logic [N_STAGE*N_RESP-1:0]   ichallenge,
  input  logic                        in_1,
  input  logic                        in_2,
  output logic                        opulse,
  output logic [N_STAGE-1:0]          ochallange,
  output logic [N_RESP-1:0]           oresponse,
  output logic                        odone,
  output logic                        obusy,
  output logic                        oerror,
  output logic [7:0]                  otie_cnt
);

  localparam int KW = (N_RESP > 1) ? $clog2(N_RESP) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES);

  localparam logic [KW-1:0] K_LAST = KW'(N_RESP - 1);
  localparam logic [3:0]    T_LAST = 4'(REPEAT - 1);
  localparam logic [3:0]    HALF   = 4'(REPEAT / 2);
  localparam logic [CW-1:0] C_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    LAUNCH    = 3'd2,
    RACE      = 3'd3,
    RETIRE    = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;

  logic                      s1_meta, s1, s2_meta, s2;
  logic [N_STAGE*N_RESP-1:0] chal_q;
  logic [KW-1:0]             k;
  logic [KW-1:0]             k_next;
  logic [3:0]                t;
  logic [3:0]                ones_cnt;
  logic [3:0]                ones_next;
  logic                      majority;
  logic                      vote;
  logic [CW-1:0]             cnt;
  logic [N_STAGE-1:0]        slices [N_RESP];

  // View of the latched challenge as one slice per response bit.
  for (genvar i = 0; i < N_RESP; i++) begin : g_slice
    assign slices[i] = chal_q[i*N_STAGE +: N_STAGE];
  end

  assign k_next    = k + KW'(1);
  assign ones_next = ones_cnt + {3'b000, vote};
  assign majority  = (ones_next > HALF);

  // Two-flop synchronisers for the racing delay-line outputs.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      s1_meta <= 1'b0;
      s1      <= 1'b0;
      s2_meta <= 1'b0;
      s2      <= 1'b0;
    end else begin
      s1_meta <= in_1;
      s1      <= s1_meta;
      s2_meta <= in_2;
      s2      <= s2_meta;
    end
  end

  // Request sequencing: precharge, launch, race decision, vote retirement.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= IDLE;
      chal_q     <= '0;
      k          <= '0;
      t          <= '0;
      ones_cnt   <= '0;
      vote       <= 1'b0;
      cnt        <= '0;
      opulse     <= 1'b0;
      ochallange <= '0;
      oresponse  <= '0;
      odone      <= 1'b0;
      obusy      <= 1'b0;
      oerror     <= 1'b0;
      otie_cnt   <= '0;
    end else begin
      odone <= 1'b0;
      case (state)
        IDLE: begin
          if (istart) begin
            chal_q     <= ichallenge;
            oresponse  <= '0;
            oerror     <= 1'b0;
            otie_cnt   <= '0;
            k          <= '0;
            t          <= '0;
            ones_cnt   <= '0;
            cnt        <= '0;
            ochallange <= ichallenge[N_STAGE-1:0];
            obusy      <= 1'b1;
            state      <= PRECHARGE;
          end
        end

        PRECHARGE: begin
          if (cnt == C_LAST) begin
            cnt <= '0;
            // Either line still high after precharge: the trial is void.
            if (s1 | s2) begin
              oerror <= 1'b1;
              vote   <= 1'b0;
              state  <= RETIRE;
            end else begin
              opulse <= 1'b1;
              state  <= LAUNCH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        LAUNCH: begin
          cnt   <= '0;
          state <= RACE;
        end

        RACE: begin
          if (s1 && !s2) begin
            vote   <= 1'b1;
            opulse <= 1'b0;
            state  <= RETIRE;
          end else if (!s1 && s2) begin
            vote   <= 1'b0;
            opulse <= 1'b0;
            state  <= RETIRE;
          end else if (s1 && s2) begin
            vote     <= 1'b0;
            opulse   <= 1'b0;
            otie_cnt <= (otie_cnt == 8'hFF) ? otie_cnt : otie_cnt + 8'd1;
            state    <= RETIRE;
          end else if (cnt == C_LAST) begin
            vote   <= 1'b0;
            oerror <= 1'b1;
            opulse <= 1'b0;
            state  <= RETIRE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RETIRE: begin
          cnt <= '0;
          if (t != T_LAST) begin
            t        <= t + 4'd1;
            ones_cnt <= ones_next;
            state    <= PRECHARGE;
          end else begin
            oresponse[k] <= majority;
            ones_cnt     <= '0;
            t            <= '0;
            if (k != K_LAST) begin
              k          <= k_next;
              ochallange <= slices[k_next];
              state      <= PRECHARGE;
            end else begin
              odone <= 1'b1;
              obusy <= 1'b0;
              state <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_response_engine.sv
// Bench for arbiter_response_engine: a delay-line model answers each launch
// pulse with per-trial arrival delays, a reference model predicts the
// response word from those delays, and a monitor checks every completion.
module tb_arbiter_response_engine;

  localparam int N_STAGE       = 3;
  localparam int N_RESP        = 8;
  localparam int REPEAT        = 3;
  localparam int SETTLE_CYCLES = 4;
  localparam int W             = N_STAGE * N_RESP;
  localparam int NEVER         = 99;

  logic                clk = 1'b0;
  logic                rst;
  logic                istart;
  logic [W-1:0]        ichallenge;
  logic                in_1, in_2;
  logic                opulse;
  logic [N_STAGE-1:0]  ochallange;
  logic [N_RESP-1:0]   oresponse;
  logic                odone, obusy, oerror;
  logic [7:0]          otie_cnt;

  arbiter_response_engine #(
    .N_STAGE(N_STAGE), .N_RESP(N_RESP), .REPEAT(REPEAT), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .iclk(clk), .irst(rst), .istart(istart), .ichallenge(ichallenge),
    .in_1(in_1), .in_2(in_2), .opulse(opulse), .ochallange(ochallange),
    .oresponse(oresponse), .odone(odone), .obusy(obusy), .oerror(oerror),
    .otie_cnt(otie_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Per-trial arrival delays (cycles after launch) for each line.
  int d1_tab [N_RESP][REPEAT];
  int d2_tab [N_RESP][REPEAT];
  bit hold_in1;

  logic [W-1:0]  cur_chal;
  int            pulse_idx;
  logic [16:0]   exp_q[$];
  int            checks;
  int            errors;
  int            done_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [N_STAGE-1:0] slice_of(input logic [W-1:0] c, input int b);
    logic [W-1:0] sh;
    sh = c >> (b * N_STAGE);
    return sh[N_STAGE-1:0];
  endfunction

  // Race cycle at which an arrival with delay d is observed, or NEVER when
  // it falls outside the race window (two-cycle input synchroniser).
  function automatic int seen_at(input int d);
    if (d + 1 <= SETTLE_CYCLES - 1) return d + 1;
    return NEVER;
  endfunction

  // Reference: predicted {response, error, tie count} for the loaded tables.
  function automatic logic [16:0] model();
    logic [7:0] resp;
    logic       err;
    int         ties, ones, a1, a2;
    resp = '0; err = 1'b0; ties = 0;
    for (int b = 0; b < N_RESP; b++) begin
      ones = 0;
      for (int tr = 0; tr < REPEAT; tr++) begin
        if (hold_in1) begin
          err = 1'b1;
        end else begin
          a1 = seen_at(d1_tab[b][tr]);
          a2 = seen_at(d2_tab[b][tr]);
          if (a1 == NEVER && a2 == NEVER) err = 1'b1;
          else if (a1 == a2) ties++;
          else if (a1 < a2) ones++;
        end
      end
      resp[b] = (2 * ones > REPEAT);
    end
    if (ties > 255) ties = 255;
    return {resp, err, 8'(ties)};
  endfunction

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < N_RESP; i++)
      for (int j = 0; j < REPEAT; j++) begin
        d1_tab[i][j] = a;
        d2_tab[i][j] = b;
      end
  endtask

  // ---------------- driver: delay-line model ----------------
  initial begin
    int pcnt, cur_d1, cur_d2, cur_bit;
    in_1 = 1'b0; in_2 = 1'b0;
    pulse_idx = 0; pcnt = 0; cur_d1 = NEVER; cur_d2 = NEVER; cur_bit = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!obusy) pulse_idx = 0;
      if (opulse) begin
        if (pcnt == 0) begin
          cur_bit = pulse_idx / REPEAT;
          if (cur_bit < N_RESP) begin
            cur_d1 = d1_tab[cur_bit][pulse_idx % REPEAT];
            cur_d2 = d2_tab[cur_bit][pulse_idx % REPEAT];
          end
          pulse_idx++;
        end
        check("challenge_slice", 32'(ochallange), 32'(slice_of(cur_chal, cur_bit)));
        pcnt++;
      end else begin
        pcnt = 0;
      end
      in_1 = hold_in1 || (opulse && pcnt > cur_d1);
      in_2 = opulse && pcnt > cur_d2;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_done;
    logic [16:0] e;
    prev_done = 1'b0;
    done_cnt  = 0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_one_cycle", 32'(odone), 32'd0);
      if (odone) begin
        done_cnt++;
        check("busy_at_done", 32'(obusy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got odone=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("response", 32'(oresponse), 32'(e[16:9]));
          check("error",    32'(oerror),    32'(e[8]));
          check("ties",     32'(otie_cnt),  32'(e[7:0]));
        end
      end
      prev_done = odone;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_req(input logic [W-1:0] chal);
    @(posedge clk);
    #1;
    cur_chal   = chal;
    ichallenge = chal;
    exp_q.push_back(model());
    istart = 1'b1;
    @(posedge clk);
    #1;
    istart = 1'b0;
  endtask

  task automatic wait_done();
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no odone in %0d cycles, expected completion", n);
      exp_q.delete();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] c;
    int           n, p;
    checks = 0; errors = 0;
    rst = 1'b1; istart = 1'b0; ichallenge = '0; hold_in1 = 1'b0; cur_chal = '0;
    set_all(1, 3);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse", 32'(opulse), 32'd0);
    check("rst_busy",  32'(obusy),  32'd0);
    check("rst_done",  32'(odone),  32'd0);
    check("rst_resp",  32'(oresponse), 32'd0);
    check("rst_err",   32'(oerror), 32'd0);
    check("rst_ties",  32'(otie_cnt), 32'd0);
    check("rst_chal",  32'(ochallange), 32'd0);
    rst = 1'b0;

    // in_1 always arrives first
    set_all(1, 3);
    start_req('0);
    wait_done();

    // winner per bit follows the parity of its challenge slice
    c = 24'hFAC688;
    for (int b = 0; b < N_RESP; b++) begin
      p = ^slice_of(c, b);
      for (int j = 0; j < REPEAT; j++) begin
        d1_tab[b][j] = p ? 1 : 3;
        d2_tab[b][j] = p ? 3 : 1;
      end
    end
    start_req(c);
    wait_done();

    // majority 2-of-3, then the inverted pattern
    for (int inv = 0; inv < 2; inv++) begin
      for (int b = 0; b < N_RESP; b++)
        for (int j = 0; j < REPEAT; j++) begin
          d1_tab[b][j] = ((j == 1) ^ (inv == 1)) ? 3 : 1;
          d2_tab[b][j] = ((j == 1) ^ (inv == 1)) ? 1 : 3;
        end
      start_req(24'h5A5A5A);
      wait_done();
    end

    // every trial ties
    set_all(1, 1);
    start_req(24'h123456);
    wait_done();

    // nothing ever arrives: every trial times out
    set_all(NEVER, NEVER);
    start_req(24'h0F0F0F);
    wait_done();

    // in_1 stuck high through precharge
    hold_in1 = 1'b1;
    start_req(24'hABCDEF);
    wait_done();
    hold_in1 = 1'b0;
    repeat (4) @(posedge clk);

    // reset during the race of bit 3
    set_all(1, 3);
    start_req(24'h777777);
    n = 0;
    while (pulse_idx < 3 * REPEAT + 1 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reached_bit3", 32'(pulse_idx >= 3 * REPEAT + 1), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_pulse", 32'(opulse), 32'd0);
    check("midrst_busy",  32'(obusy),  32'd0);
    check("midrst_resp",  32'(oresponse), 32'd0);
    check("midrst_err",   32'(oerror), 32'd0);
    check("midrst_ties",  32'(otie_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());

    // fresh request; extra istart pulses while busy are ignored
    set_all(1, 3);
    start_req(24'h000000);
    repeat (7) @(posedge clk);
    #1;
    ichallenge = 24'hFFFFFF; istart = 1'b1;
    @(posedge clk);
    #1;
    istart = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_start", 32'(obusy), 32'd0);

    // randomized delays and challenges
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < N_RESP; b++)
        for (int j = 0; j < REPEAT; j++) begin
          d1_tab[b][j] = $urandom_range(0, 4);
          d2_tab[b][j] = ($urandom_range(0, 3) == 0) ? d1_tab[b][j] : int'($urandom_range(0, 4));
        end
      start_req(W'($urandom));
      wait_done();
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expect: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
